// File: rtl/param_grant_arbiter_pkg.sv
// Shared types and helpers for the parameterised grant arbiter.
// State encoding and a one-hot to index conversion used by the top level.
package param_grant_arbiter_pkg;

   localparam int MAX_REQ = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Index of the lowest set bit; returns 0 for an all-zero vector.
   function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/param_grant_arbiter_rr_priority_pick.sv
// Circular priority picker: first request at or after start, wrapping,
// ignoring channels set in exclude. Fixed priority is start = 0.
module param_grant_arbiter_rr_priority_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    start,
   input  logic [NUM_REQ-1:0] exclude,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   logic [NUM_REQ-1:0] cand;

   assign cand = req & ~exclude;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int pos;
         pos = (int'(start) + k) % NUM_REQ;
         if (!found && cand[pos]) begin
            found = 1'b1;
            idx   = ID_W'(pos);
         end
      end
   end

endmodule

// File: rtl/param_grant_arbiter.sv
// N-requester grant arbiter: fixed-priority or round-robin selection, direct
// hand-off between owners and a hold limit that forces release when others wait.
module param_grant_arbiter
   import param_grant_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               mode,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               preempt,
   output logic               state_dbg
);

   localparam int HOLD_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SAT);

   arb_state_t         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [HOLD_W-1:0]  hold_cnt;

   logic [NUM_REQ-1:0] excl_mask;
   logic [ID_W-1:0]    pick_start;
   logic [ID_W-1:0]    win_idx;
   logic               win_found;
   logic [NUM_REQ-1:0] win_onehot;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    ptr_next;
   logic               owner_req;
   logic               hold_ok;

   // The current owner never competes in its own release decision.
   assign excl_mask  = (state == ST_GRANT) ? (NUM_REQ'(1) << gnt_id) : '0;
   assign pick_start = mode ? rr_ptr : '0;

   param_grant_arbiter_rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (req),
      .start   (pick_start),
      .exclude (excl_mask),
      .idx     (win_idx),
      .found   (win_found)
   );

   assign win_onehot = NUM_REQ'(1) << win_idx;
   assign win_id     = ID_W'(onehot_to_idx(MAX_REQ'(win_onehot)));
   assign ptr_next   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
   assign owner_req  = req[gnt_id];
   assign hold_ok    = (MAX_HOLD == 0) || (int'(hold_cnt) < MAX_HOLD) || !win_found;
   assign state_dbg  = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         preempt   <= 1'b0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
      end else begin
         preempt <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (win_found) begin
                  state     <= ST_GRANT;
                  gnt       <= win_onehot;
                  gnt_valid <= 1'b1;
                  gnt_id    <= win_id;
                  hold_cnt  <= HOLD_W'(1);
                  rr_ptr    <= ptr_next;
               end
            end
            ST_GRANT: begin
               if (owner_req && hold_ok) begin
                  if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
               end else if (win_found) begin
                  // Reaching here with the owner still requesting means the hold limit fired.
                  gnt       <= win_onehot;
                  gnt_valid <= 1'b1;
                  gnt_id    <= win_id;
                  hold_cnt  <= HOLD_W'(1);
                  rr_ptr    <= ptr_next;
                  preempt   <= owner_req;
               end else begin
                  state     <= ST_IDLE;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  gnt_id    <= '0;
                  hold_cnt  <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
